// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes,
// ALUOp codes (also used by the ALU control block) and datapath mux selects.
package mips_mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State that follows DECODE for a given opcode; unknown opcodes trap.
  function automatic logic [3:0] decode_dispatch(input logic [5:0] op);
    logic [3:0] nxt;
    case (op)
      OP_RTYPE:      nxt = S_EXEC;
      OP_LW, OP_SW:  nxt = S_MEMADR;
      OP_BEQ, OP_BNE: nxt = S_BRANCH;
      OP_J:          nxt = S_JUMP;
      OP_ADDI:       nxt = S_ADDIEX;
      default:       nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface mips_mc_control_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               illegal;
  logic               retire;
  logic [CNT_W-1:0]   instr_count;
  logic [3:0]         state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, retire,
           instr_count, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, retire,
           instr_count, state
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing one instruction over
// 3-5 cycles, with memory-ready stalls, an illegal-opcode trap and a
// retired-instruction counter. All outputs are forced low while reset is high.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MEM = 1,
  parameter int CNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_mc_control_if.master    bus
);

  logic [3:0]       state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mr;

  logic       pc_write, branch_eq, branch_ne;
  logic       c_i_or_d, c_mem_read, c_mem_write, c_ir_write;
  logic       c_mem_to_reg, c_reg_dst, c_reg_write, c_alu_src_a, c_retire;
  logic [1:0] c_alu_src_b, c_pc_source;
  logic [2:0] c_alu_op;

  assign mr = (WAIT_MEM == 0) ? 1'b1 : bus.mem_ready;

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mr) state_d = S_DECODE;
      S_DECODE:  state_d = decode_dispatch(bus.opcode);
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mr) state_d = S_MEMWB;
      S_MEMWR:   if (mr) state_d = S_FETCH;
      S_EXEC:    state_d = S_RWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  // Moore output decode from the registered state (plus mr gating in FETCH/MEMWR).
  always_comb begin
    pc_write     = 1'b0;
    branch_eq    = 1'b0;
    branch_ne    = 1'b0;
    c_i_or_d     = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_ir_write   = 1'b0;
    c_mem_to_reg = 1'b0;
    c_reg_dst    = 1'b0;
    c_reg_write  = 1'b0;
    c_alu_src_a  = 1'b0;
    c_retire     = 1'b0;
    c_alu_src_b  = SRCB_RT;
    c_pc_source  = PCSRC_ALU;
    c_alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        c_mem_read  = 1'b1;
        c_alu_src_b = SRCB_FOUR;
        c_ir_write  = mr;
        pc_write    = mr;
      end
      S_DECODE: c_alu_src_b = SRCB_IMMSH2;
      S_MEMADR, S_ADDIEX: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c_mem_read = 1'b1;
        c_i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c_reg_write  = 1'b1;
        c_mem_to_reg = 1'b1;
        c_retire     = 1'b1;
      end
      S_MEMWR: begin
        c_mem_write = 1'b1;
        c_i_or_d    = 1'b1;
        c_retire    = mr;
      end
      S_EXEC: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        c_reg_write = 1'b1;
        c_reg_dst   = 1'b1;
        c_retire    = 1'b1;
      end
      S_BRANCH: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = ALUOP_SUB;
        c_pc_source = PCSRC_ALUOUT;
        branch_eq   = (bus.opcode == OP_BEQ);
        branch_ne   = (bus.opcode == OP_BNE);
        c_retire    = 1'b1;
      end
      S_JUMP: begin
        c_pc_source = PCSRC_JUMP;
        pc_write    = 1'b1;
        c_retire    = 1'b1;
      end
      S_ADDIWB: begin
        c_reg_write = 1'b1;
        c_retire    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, sticky trap flag and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_ILLEGAL);
      if (c_retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_en       = ~reset & (pc_write | (branch_eq & bus.zero) | (branch_ne & ~bus.zero));
  assign bus.i_or_d      = ~reset & c_i_or_d;
  assign bus.mem_read    = ~reset & c_mem_read;
  assign bus.mem_write   = ~reset & c_mem_write;
  assign bus.ir_write    = ~reset & c_ir_write;
  assign bus.mem_to_reg  = ~reset & c_mem_to_reg;
  assign bus.reg_dst     = ~reset & c_reg_dst;
  assign bus.reg_write   = ~reset & c_reg_write;
  assign bus.alu_src_a   = ~reset & c_alu_src_a;
  assign bus.alu_src_b   = reset ? 2'b00 : c_alu_src_b;
  assign bus.alu_op      = reset ? '0 : ALUOP_W'(c_alu_op);
  assign bus.pc_source   = reset ? 2'b00 : c_pc_source;
  assign bus.illegal     = ~reset & illegal_q;
  assign bus.retire      = ~reset & c_retire;
  assign bus.instr_count = reset ? '0 : cnt_q;
  assign bus.state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control: per-instruction expected traces are
// built from opcode and memory-wait counts, and each cycle's controls are
// compared against a per-state table of the documented outputs.
module tb_mips_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cnt_m = 0;

  step_t       trace[$];
  logic [3:0]  obs_st[$];
  logic [17:0] obs_wq[$];
  logic [17:0] obs_w;
  logic [17:0] ew;

  mips_mc_control_if #(.ALUOP_W(3), .CNT_W(32)) bus();

  mips_mc_control #(.ALUOP_W(3), .WAIT_MEM(1), .CNT_W(32)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  assign obs_w = {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                  bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal, bus.retire};

  // Documented outputs for one cycle, keyed by state number.
  function automatic logic [17:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                           input logic z, input logic mr);
    logic pcw, pce, iod, mrd, mwr, irw, m2r, rdst, rw, sa, ill, ret;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    pcw = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0; rw = 0;
    sa = 0; ill = 0; ret = 0; sb = 2'd0; ps = 2'd0; ao = 3'd0;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; ret = 1; end
      4'd5:  begin mwr = 1; iod = 1; ret = mr; end
      4'd6:  begin sa = 1; ao = 3'b010; end
      4'd7:  begin rw = 1; rdst = 1; ret = 1; end
      4'd8:  begin sa = 1; ao = 3'b001; ps = 2'b01; ret = 1; end
      4'd9:  begin ps = 2'b10; pcw = 1; ret = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; ret = 1; end
      4'd12: ill = 1;
      default: ;
    endcase
    pce = pcw | ((st == 4'd8) && ((op == 6'h04 && z) || (op == 6'h05 && !z)));
    return {pce, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, ill, ret};
  endfunction

  function automatic step_t mk(input int st, input logic mr);
    step_t s;
    s.st = st[3:0];
    s.mr = mr;
    return s;
  endfunction

  // Expected state sequence of one instruction starting in FETCH.
  task automatic build_trace(input logic [5:0] op, input int fw, input int mw);
    trace.delete();
    for (int i = 0; i < fw; i++) trace.push_back(mk(0, 1'b0));
    trace.push_back(mk(0, 1'b1));
    trace.push_back(mk(1, 1'($urandom)));
    case (op)
      6'h00: begin trace.push_back(mk(6, 1'($urandom))); trace.push_back(mk(7, 1'($urandom))); end
      6'h23: begin
        trace.push_back(mk(2, 1'($urandom)));
        for (int i = 0; i < mw; i++) trace.push_back(mk(3, 1'b0));
        trace.push_back(mk(3, 1'b1));
        trace.push_back(mk(4, 1'($urandom)));
      end
      6'h2B: begin
        trace.push_back(mk(2, 1'($urandom)));
        for (int i = 0; i < mw; i++) trace.push_back(mk(5, 1'b0));
        trace.push_back(mk(5, 1'b1));
      end
      6'h04, 6'h05: trace.push_back(mk(8, 1'($urandom)));
      6'h02: trace.push_back(mk(9, 1'($urandom)));
      6'h08: begin trace.push_back(mk(10, 1'($urandom))); trace.push_back(mk(11, 1'($urandom))); end
      default: for (int i = 0; i < 20; i++) trace.push_back(mk(12, 1'($urandom)));
    endcase
  endtask

  // Drive mem_ready per step from a negedge and record what the DUT shows.
  task automatic play();
    obs_st.delete();
    obs_wq.delete();
    foreach (trace[i]) begin
      bus.mem_ready = trace[i].mr;
      #1;
      obs_st.push_back(bus.state);
      obs_wq.push_back(obs_w);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      tests++;
      if (obs_w !== 18'd0 || bus.state !== 4'd0 || bus.instr_count !== 32'd0) begin
        fails++;
        $display("FAIL reset_outputs: ctl=%05h state=%0d count=%0d, expected 0/0/0", obs_w, bus.state, bus.instr_count);
      end
    end
    rst = 1'b0;
    cnt_m = 0;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.instr_count !== 32'd0 || bus.illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: state=%0d count=%0d illegal=%b, expected 0/0/0", bus.state, bus.instr_count, bus.illegal);
    end
    build_trace(6'h00, 0, 0);
    play();
    foreach (trace[i]) begin
      ew = exp_word(trace[i].st, 6'h00, 1'b0, trace[i].mr);
      tests++;
      if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
        fails++;
        $display("FAIL rtype cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h", i, obs_st[i], obs_wq[i], trace[i].st, ew);
      end
      cnt_m += int'(ew[0]);
    end
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.instr_count !== 32'd1) begin
      fails++;
      $display("FAIL rtype_end: state=%0d count=%0d, expected 0/1", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_lw_wait();
    bus.opcode = 6'h23;
    build_trace(6'h23, 3, 2);
    play();
    foreach (trace[i]) begin
      ew = exp_word(trace[i].st, 6'h23, 1'b0, trace[i].mr);
      tests++;
      if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
        fails++;
        $display("FAIL lw_wait cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h", i, obs_st[i], obs_wq[i], trace[i].st, ew);
      end
      cnt_m += int'(ew[0]);
    end
    #1;
    tests++;
    if (bus.instr_count !== 32'(cnt_m) || trace.size() != 10) begin
      fails++;
      $display("FAIL lw_count: count=%0d, expected %0d", bus.instr_count, cnt_m);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[4];
    logic       zs[4];
    ops[0] = 6'h04; zs[0] = 1'b1;
    ops[1] = 6'h05; zs[1] = 1'b1;
    ops[2] = 6'h05; zs[2] = 1'b0;
    ops[3] = 6'h04; zs[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.opcode = ops[k];
      bus.zero   = zs[k];
      build_trace(ops[k], int'($urandom_range(0, 2)), 0);
      play();
      foreach (trace[i]) begin
        ew = exp_word(trace[i].st, ops[k], zs[k], trace[i].mr);
        tests++;
        if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
          fails++;
          $display("FAIL branch op=%02h zero=%b cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                   ops[k], zs[k], i, obs_st[i], obs_wq[i], trace[i].st, ew);
        end
        cnt_m += int'(ew[0]);
      end
    end
  endtask

  task automatic test_sw_j();
    logic [31:0] c0;
    logic [5:0]  ops[2];
    ops[0] = 6'h2B;
    ops[1] = 6'h02;
    #1;
    c0 = bus.instr_count;
    for (int k = 0; k < 2; k++) begin
      bus.opcode = ops[k];
      build_trace(ops[k], 0, int'($urandom_range(0, 3)));
      play();
      foreach (trace[i]) begin
        ew = exp_word(trace[i].st, ops[k], 1'b0, trace[i].mr);
        tests++;
        if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
          fails++;
          $display("FAIL sw_j op=%02h cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                   ops[k], i, obs_st[i], obs_wq[i], trace[i].st, ew);
        end
        cnt_m += int'(ew[0]);
      end
    end
    #1;
    tests++;
    if (bus.instr_count !== c0 + 32'd2) begin
      fails++;
      $display("FAIL sw_j_count: count=%0d, expected %0d", bus.instr_count, c0 + 32'd2);
    end
  endtask

  task automatic test_illegal();
    bus.opcode = 6'h3F;
    build_trace(6'h3F, 0, 0);
    play();
    foreach (trace[i]) begin
      ew = exp_word(trace[i].st, 6'h3F, 1'b0, trace[i].mr);
      tests++;
      if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
        fails++;
        $display("FAIL illegal cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h", i, obs_st[i], obs_wq[i], trace[i].st, ew);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    bus.opcode = 6'h00;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.illegal !== 1'b0 || bus.instr_count !== 32'd0) begin
      fails++;
      $display("FAIL illegal_clear: state=%0d illegal=%b count=%0d, expected 0/0/0", bus.state, bus.illegal, bus.instr_count);
    end
  endtask

  task automatic test_reset_mid_sw();
    bus.opcode = 6'h2B;
    trace.delete();
    trace.push_back(mk(0, 1'b1));
    trace.push_back(mk(1, 1'b1));
    trace.push_back(mk(2, 1'b1));
    trace.push_back(mk(5, 1'b0));
    trace.push_back(mk(5, 1'b0));
    play();
    foreach (trace[i]) begin
      ew = exp_word(trace[i].st, 6'h2B, 1'b0, trace[i].mr);
      tests++;
      if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
        fails++;
        $display("FAIL mid_sw cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h", i, obs_st[i], obs_wq[i], trace[i].st, ew);
      end
    end
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    tests++;
    if (bus.mem_write !== 1'b0 || obs_w !== 18'd0) begin
      fails++;
      $display("FAIL mid_sw_reset_cycle: mem_write=%b ctl=%05h, expected 0/00000", bus.mem_write, obs_w);
    end
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.instr_count !== 32'd0) begin
      fails++;
      $display("FAIL mid_sw_after: state=%0d count=%0d, expected 0/0", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_random();
    logic [5:0] legal[7];
    logic [5:0] op;
    logic       z;
    legal[0] = 6'h00; legal[1] = 6'h23; legal[2] = 6'h2B; legal[3] = 6'h04;
    legal[4] = 6'h05; legal[5] = 6'h02; legal[6] = 6'h08;
    for (int n = 0; n < 24; n++) begin
      op = legal[$urandom_range(0, 6)];
      z  = 1'($urandom);
      bus.opcode = op;
      bus.zero   = z;
      build_trace(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      play();
      foreach (trace[i]) begin
        ew = exp_word(trace[i].st, op, z, trace[i].mr);
        tests++;
        if (obs_st[i] !== trace[i].st || obs_wq[i] !== ew) begin
          fails++;
          $display("FAIL random n=%0d op=%02h cycle %0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                   n, op, i, obs_st[i], obs_wq[i], trace[i].st, ew);
        end
        cnt_m += int'(ew[0]);
      end
      #1;
      tests++;
      if (bus.instr_count !== 32'(cnt_m)) begin
        fails++;
        $display("FAIL random_count n=%0d: count=%0d, expected %0d", n, bus.instr_count, cnt_m);
      end
    end
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_lw_wait();
    test_branch();
    test_sw_j();
    test_reset_mid_sw();
    test_random();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences one MIPS instruction over 3–5 cycles.
- Sits beside the shared ALU, register file and PC in the multi-cycle datapath; drives every datapath enable and mux select.
- Adds behaviour the single-cycle decoder lacks: a memory ready handshake, ADDI support, an illegal-opcode trap, and a retired-instruction counter.

Parameters:
- ALUOP_W, 3, width of alu_op; must match the ALU control input.
- WAIT_MEM, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
- CNT_W, 32, width of instr_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC load = pc_write | (branch_eq & zero) | (branch_ne & ~zero).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register-file write data: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  ALUOP_W  000 = add, 001 = sub, 010 = use funct.
- pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  sticky trap flag.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_count  out  CNT_W  count of retired instructions.
- state  out  4  current FSM state, for debug.

Behaviour:
- Outputs are decoded from the registered state. Any output not listed for a state is 0. Internal strobes are pc_write, branch_eq and branch_ne; mr means mem_ready, forced to 1 when WAIT_MEM = 0.
- Reset cycle: every output is 0, including pc_en, ir_write, reg_write, mem_write and mem_read. On the next edge: state <= FETCH, illegal <= 0, instr_count <= 0. Reset mid-instruction aborts that instruction with no write.
- FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00. ir_write and pc_write are asserted only when mr. mr -> DECODE; otherwise stay in FETCH.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=add (precomputes the branch target). Next state by opcode:
  - 0x00 -> EXEC; 0x23 or 0x2B -> MEMADR; 0x04 or 0x05 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX; any other opcode -> ILLEGAL.
- MEMADR (2): alu_src_a=1, alu_src_b=10, add. Opcode 0x23 -> MEMRD; 0x2B -> MEMWR.
- MEMRD (3): mem_read=1, i_or_d=1. mr -> MEMWB; otherwise hold.
- MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0, retire. -> FETCH.
- MEMWR (5): mem_write=1, i_or_d=1. mr -> FETCH with retire; otherwise hold. mem_write stays high for the whole wait.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=funct. -> RWB.
- RWB (7): reg_write=1, reg_dst=1, mem_to_reg=0, retire. -> FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, sub, pc_source=01. branch_eq = (opcode == 0x04); branch_ne = (opcode == 0x05). retire. -> FETCH.
- JUMP (9): pc_source=10, pc_write=1, retire. -> FETCH.
- ADDIEX (10): alu_src_a=1, alu_src_b=10, add. -> ADDIWB.
- ADDIWB (11): reg_write=1, reg_dst=0, mem_to_reg=0, retire. -> FETCH.
- ILLEGAL (12): illegal=1; all enables 0. Only reset leaves this state.
- State encodings 13–15 are unreachable. If entered, go to ILLEGAL.
- instr_count increments by 1 on every retire cycle and wraps modulo 2^CNT_W.
- Latencies with mr=1 in every memory state: R-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3, ADDI 4.

Decomposition:
- Package mips_mc_pkg holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI);
  - ALUOp encodings, shared with the ALU control block;
  - alu_src_b and pc_source select codes.
- No sub-module: this is one FSM with a next-state block, an output decode and a counter.

Test Plan:
- Reset held 2 cycles, then released with opcode=0x00 and mr=1 -> state FETCH, all enables 0 during reset, instr_count=0. States then run 0,1,6,7,0; retire pulses in the RWB cycle; instr_count=1.
- LW (0x23) with mr low for 3 cycles in FETCH and 2 cycles in MEMRD -> FETCH is held 4 cycles with ir_write=0 until mr; MEMRD is held 3 cycles with mem_read=1, i_or_d=1. Total 10 cycles; reg_write=1 and mem_to_reg=1 in MEMWB.
- BEQ (0x04) with zero=1 -> pc_en=1 in BRANCH. BNE (0x05) with zero=1 -> pc_en=0. BNE with zero=0 -> pc_en=1. All cases use pc_source=01 and sub.
- SW (0x2B) then J (0x02) -> MEMWR has mem_write=1, reg_write=0. JUMP has pc_source=10, pc_en=1. instr_count advances by 2.
- Opcode 0x3F -> DECODE -> ILLEGAL; illegal stays 1 and all enables stay 0 for 20 cycles. Reset clears illegal and returns to FETCH.
- Reset asserted in MEMWR while mr=0 -> mem_write=0 in the reset cycle; next state FETCH; instr_count=0.
